// File: rtl/tb_fetch_scheduler_if.sv
// Host / memory / transpose-buffer / consumer signal bundle for tb_fetch_scheduler.
interface tb_fetch_scheduler_if #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned TB_HEIGHT   = 3,
  parameter int unsigned ADDR_W      = 16
);
  localparam int unsigned ROW_W = $clog2(TB_HEIGHT);
  localparam int unsigned COL_W = $clog2(FETCH_WIDTH);

  logic                   start;
  logic [ADDR_W-1:0]      cfg_base;
  logic [ADDR_W-1:0]      cfg_stride;
  logic [7:0]             cfg_num_tiles;
  logic [FETCH_WIDTH-1:0] cfg_lane_mask;
  logic                   mem_ren;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   tb_wen;
  logic                   tb_wr_bank;
  logic [ROW_W-1:0]       tb_wr_row;
  logic [FETCH_WIDTH-1:0] tb_valid_input;
  logic                   out_valid;
  logic                   out_ready;
  logic                   tb_rd_bank;
  logic [COL_W-1:0]       tb_rd_col;
  logic                   busy;
  logic                   done;

  // Host/consumer side
  modport master (
    output start, cfg_base, cfg_stride, cfg_num_tiles, cfg_lane_mask, out_ready,
    input  mem_ren, mem_addr, tb_wen, tb_wr_bank, tb_wr_row, tb_valid_input,
           out_valid, tb_rd_bank, tb_rd_col, busy, done
  );

  // Scheduler side
  modport slave (
    input  start, cfg_base, cfg_stride, cfg_num_tiles, cfg_lane_mask, out_ready,
    output mem_ren, mem_addr, tb_wen, tb_wr_bank, tb_wr_row, tb_valid_input,
           out_valid, tb_rd_bank, tb_rd_col, busy, done
  );
endinterface

// File: rtl/tb_fetch_scheduler.sv
// Double-banked transpose-buffer sequencer: issues row reads, steers returning
// rows into the fill bank and drains full banks column by column.
// All outputs are flops; mem_ren/out_valid/busy are computed one cycle ahead
// from the next-state values so they line up with the state they describe.
module tb_fetch_scheduler #(
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned TB_HEIGHT   = 3,
  parameter int unsigned ADDR_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  tb_fetch_scheduler_if.slave bus
);
  localparam int unsigned ROW_W = $clog2(TB_HEIGHT);
  localparam int unsigned COL_W = $clog2(FETCH_WIDTH);
  localparam int unsigned CNT_W = 8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TB_HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FETCH_WIDTH - 1);

  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       num_tiles_q, num_tiles_d;
  logic [ADDR_W-1:0]      stride_q, stride_d;
  logic [FETCH_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   iss_bank_q, iss_bank_d;
  logic [ROW_W-1:0]       iss_row_q, iss_row_d;
  logic [CNT_W-1:0]       iss_tiles_q, iss_tiles_d;
  logic [1:0]             alloc_q, alloc_d;
  logic [1:0]             full_q, full_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [COL_W-1:0]       rd_col_q, rd_col_d;
  logic [CNT_W-1:0]       done_tiles_q, done_tiles_d;
  logic                   mem_ren_q, mem_ren_d;
  logic                   tb_wen_q, tb_wen_d;
  logic                   wr_bank_q, wr_bank_d;
  logic [ROW_W-1:0]       wr_row_q, wr_row_d;
  logic [FETCH_WIDTH-1:0] valid_in_q, valid_in_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fire;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      num_tiles_q  <= '0;
      stride_q     <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      iss_bank_q   <= 1'b0;
      iss_row_q    <= '0;
      iss_tiles_q  <= '0;
      alloc_q      <= '0;
      full_q       <= '0;
      rd_bank_q    <= 1'b0;
      rd_col_q     <= '0;
      done_tiles_q <= '0;
      mem_ren_q    <= 1'b0;
      tb_wen_q     <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_row_q     <= '0;
      valid_in_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_tiles_q  <= num_tiles_d;
      stride_q     <= stride_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      iss_bank_q   <= iss_bank_d;
      iss_row_q    <= iss_row_d;
      iss_tiles_q  <= iss_tiles_d;
      alloc_q      <= alloc_d;
      full_q       <= full_d;
      rd_bank_q    <= rd_bank_d;
      rd_col_q     <= rd_col_d;
      done_tiles_q <= done_tiles_d;
      mem_ren_q    <= mem_ren_d;
      tb_wen_q     <= tb_wen_d;
      wr_bank_q    <= wr_bank_d;
      wr_row_q     <= wr_row_d;
      valid_in_q   <= valid_in_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state: issue, write-back, drain and run control
  always_comb begin
    state_d      = state_q;
    num_tiles_d  = num_tiles_q;
    stride_d     = stride_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    iss_bank_d   = iss_bank_q;
    iss_row_d    = iss_row_q;
    iss_tiles_d  = iss_tiles_q;
    alloc_d      = alloc_q;
    full_d       = full_q;
    rd_bank_d    = rd_bank_q;
    rd_col_d     = rd_col_q;
    done_tiles_d = done_tiles_q;
    done_d       = 1'b0;
    fire         = out_valid_q & bus.out_ready;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_tiles_d  = bus.cfg_num_tiles;
          stride_d     = bus.cfg_stride;
          mask_d       = bus.cfg_lane_mask;
          addr_d       = bus.cfg_base;
          iss_bank_d   = 1'b0;
          iss_row_d    = '0;
          iss_tiles_d  = '0;
          alloc_d      = '0;
          full_d       = '0;
          rd_bank_d    = 1'b0;
          rd_col_d     = '0;
          done_tiles_d = '0;
          if (bus.cfg_num_tiles == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // Row read issued this cycle claims the bank and advances the address
        if (mem_ren_q) begin
          alloc_d[iss_bank_q] = 1'b1;
          addr_d              = addr_q + stride_q;
          if (iss_row_q == LAST_ROW) begin
            iss_row_d   = '0;
            iss_bank_d  = ~iss_bank_q;
            iss_tiles_d = iss_tiles_q + CNT_W'(1);
          end else begin
            iss_row_d = iss_row_q + ROW_W'(1);
          end
        end
        // Last row landing makes the bank drainable from the next cycle
        if (tb_wen_q && (wr_row_q == LAST_ROW)) begin
          full_d[wr_bank_q] = 1'b1;
        end
        // Column handshake; the last column releases the bank
        if (fire) begin
          if (rd_col_q == LAST_COL) begin
            rd_col_d           = '0;
            alloc_d[rd_bank_q] = 1'b0;
            full_d[rd_bank_q]  = 1'b0;
            rd_bank_d          = ~rd_bank_q;
            done_tiles_d       = done_tiles_q + CNT_W'(1);
            if ((done_tiles_q + CNT_W'(1)) == num_tiles_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            rd_col_d = rd_col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_ren_d   = (state_d == S_RUN) &&
                  ((iss_row_d != '0) || !alloc_d[iss_bank_d]) &&
                  (iss_tiles_d < num_tiles_d);
    out_valid_d = (state_d == S_RUN) && full_d[rd_bank_d];
    busy_d      = (state_d == S_RUN);
    tb_wen_d    = mem_ren_q;
    wr_bank_d   = iss_bank_q;
    wr_row_d    = iss_row_q;
    valid_in_d  = mem_ren_q ? mask_q : '0;
  end

  assign bus.mem_ren        = mem_ren_q;
  assign bus.mem_addr       = addr_q;
  assign bus.tb_wen         = tb_wen_q;
  assign bus.tb_wr_bank     = wr_bank_q;
  assign bus.tb_wr_row      = wr_row_q;
  assign bus.tb_valid_input = valid_in_q;
  assign bus.out_valid      = out_valid_q;
  assign bus.tb_rd_bank     = rd_bank_q;
  assign bus.tb_rd_col      = rd_col_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule

// File: tb/tb_tb_fetch_scheduler.sv
// Bench for tb_fetch_scheduler: directed timing scenarios plus randomized jobs
// checked against a transaction-level model (address/row/column sequences,
// bank occupancy bound, run completion counts).
module tb_tb_fetch_scheduler;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 16;

  logic clk;
  logic rst;

  tb_fetch_scheduler_if #(.FETCH_WIDTH(W), .TB_HEIGHT(H), .ADDR_W(AW)) bus ();

  tb_fetch_scheduler #(.FETCH_WIDTH(W), .TB_HEIGHT(H), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int          ren_cyc[$];
  logic [15:0] ren_addr[$];
  int          wen_cyc[$];
  int          ov_cyc[$];
  int          acc_cyc[$];
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check_zero(input string tag);
    logic [31:0] v;
    v = 32'({bus.mem_ren, bus.mem_addr, bus.tb_wen, bus.tb_wr_bank, bus.tb_wr_row,
             bus.tb_valid_input, bus.out_valid, bus.tb_rd_bank, bus.tb_rd_col,
             bus.busy, bus.done});
    check(tag, v, 32'd0);
  endtask

  // One job: cycle 0 = start cycle; outputs sampled #1 after each edge.
  task automatic run_job(input logic [15:0] base, input logic [15:0] stride,
                         input logic [7:0] ntiles, input logic [3:0] mask,
                         input bit rnd_ready, input int stall_lo, input int stall_hi,
                         input int glitch_cyc, input int abort_cyc);
    int cyc, n_iss, n_wr, n_acc, total_cols, bubbles, misc, busy_err;
    bit prev_ren, seen_ov, finished, aborted, rdy, exp_busy, always_rdy;
    logic [15:0] exp_addr;
    ren_cyc.delete(); ren_addr.delete(); wen_cyc.delete();
    ov_cyc.delete(); acc_cyc.delete();
    done_cyc = -1;
    total_cols = int'(ntiles) * W;
    n_iss = 0; n_wr = 0; n_acc = 0; bubbles = 0; misc = 0; busy_err = 0;
    prev_ren = 0; seen_ov = 0; finished = 0; aborted = 0;
    always_rdy = !rnd_ready && (stall_lo > stall_hi);

    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.cfg_base = base;
    bus.cfg_stride = stride;
    bus.cfg_num_tiles = ntiles;
    bus.cfg_lane_mask = mask;
    bus.out_ready = 1'b0;
    cyc = 0;

    while (!finished && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == glitch_cyc);
      bus.cfg_base = 16'($urandom);
      bus.cfg_stride = 16'($urandom);
      bus.cfg_num_tiles = 8'($urandom);
      bus.cfg_lane_mask = 4'($urandom);
      if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
        check_zero("outputs_after_reset");
        rst = 1'b0;
        finished = 1;
        aborted = 1;
        break;
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : !(cyc >= stall_lo && cyc <= stall_hi);
      bus.out_ready = rdy;

      exp_busy = (ntiles != 0) && (n_acc < total_cols);
      if (bus.busy !== exp_busy) busy_err++;
      if (bus.tb_wen !== prev_ren) misc++;

      if (bus.out_valid === 1'b1) begin
        ov_cyc.push_back(cyc);
        if (n_wr < (n_acc / W + 1) * H) misc++;
        seen_ov = 1;
        check("rd_col", 32'(bus.tb_rd_col), n_acc % W);
        check("rd_bank", 32'(bus.tb_rd_bank), (n_acc / W) % 2);
        if (rdy) begin
          acc_cyc.push_back(cyc);
          n_acc++;
        end
      end else if (seen_ov && always_rdy && n_acc < total_cols) begin
        bubbles++;
      end

      if (bus.mem_ren === 1'b1) begin
        exp_addr = 16'(base + 16'(n_iss) * stride);
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
        ren_cyc.push_back(cyc);
        ren_addr.push_back(bus.mem_addr);
        n_iss++;
      end
      if ((n_iss + H - 1) / H - n_acc / W > 2) misc++;

      if (bus.tb_wen === 1'b1) begin
        check("wr_row", 32'(bus.tb_wr_row), n_wr % H);
        check("wr_bank", 32'(bus.tb_wr_bank), (n_wr / H) % 2);
        check("valid_input", 32'(bus.tb_valid_input), 32'(mask));
        wen_cyc.push_back(cyc);
        n_wr++;
      end else if (bus.tb_valid_input !== 4'd0) begin
        misc++;
      end

      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        finished = 1;
        check("cols_at_done", n_acc, total_cols);
        check("issues_at_done", n_iss, int'(ntiles) * H);
        check("writes_at_done", n_wr, int'(ntiles) * H);
      end
      prev_ren = bus.mem_ren;
      if (abort_cyc > 0 && cyc == abort_cyc) rst = 1'b1;
    end

    check("job_finished", 32'(finished), 32'd1);
    if (finished && !aborted) begin
      @(posedge clk); #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("busy_after_done", 32'(bus.busy), 32'd0);
    end
    bus.out_ready = 1'b0;
    check("output_bubbles", bubbles, 0);
    check("protocol_errors", misc, 0);
    check("busy_errors", busy_err, 0);
  endtask

  task automatic check_single_tile_timing(input string pfx);
    check({pfx, "_ren_count"}, ren_cyc.size(), 3);
    check({pfx, "_first_ren"}, q_at(ren_cyc, 0), 1);
    check({pfx, "_last_ren"}, q_at(ren_cyc, 2), 3);
    check({pfx, "_first_wen"}, q_at(wen_cyc, 0), 2);
    check({pfx, "_last_wen"}, q_at(wen_cyc, 2), 4);
    check({pfx, "_first_col"}, q_at(ov_cyc, 0), 5);
    check({pfx, "_last_col"}, q_at(ov_cyc, 3), 8);
    check({pfx, "_done"}, done_cyc, 9);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_stride = '0;
    bus.cfg_num_tiles = '0;
    bus.cfg_lane_mask = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;

    // Single tile, base 0x10 stride 2
    run_job(16'h0010, 16'h0002, 8'd1, 4'hF, 0, 1, 0, -1, 0);
    check_single_tile_timing("s1");
    check("s1_addr2", 32'((ren_addr.size() > 2) ? ren_addr[2] : 16'hDEAD), 32'h14);

    // Three tiles, always ready
    run_job(16'h0100, 16'h0008, 8'd3, 4'h5, 0, 1, 0, -1, 0);
    check("t3_col_count", ov_cyc.size(), 12);
    check("t3_first_col", q_at(ov_cyc, 0), 5);
    check("t3_last_col", q_at(ov_cyc, 11), 16);
    check("t3_ren_count", ren_cyc.size(), 9);
    check("t3_done", done_cyc, 17);

    // Backpressure: ready low cycles 5..20
    run_job(16'h2000, 16'h0010, 8'd2, 4'hA, 0, 5, 20, -1, 0);
    check("bp_ren_count", ren_cyc.size(), 6);
    check("bp_last_ren", q_at(ren_cyc, 5), 6);
    check("bp_valid_cycles", ov_cyc.size(), 24);
    check("bp_first_acc", q_at(acc_cyc, 0), 21);
    check("bp_last_acc", q_at(acc_cyc, 7), 28);
    check("bp_done", done_cyc, 29);

    // Zero tiles
    run_job(16'h0300, 16'h0001, 8'd0, 4'hF, 0, 1, 0, -1, 0);
    check("zero_done", done_cyc, 1);
    check("zero_ren_count", ren_cyc.size(), 0);

    // Start pulse during RUN is ignored
    run_job(16'h0400, 16'h0004, 8'd2, 4'h3, 0, 1, 0, 3, 0);
    check("glitch_ren_count", ren_cyc.size(), 6);
    check("glitch_done", done_cyc, 13);

    // Address wrap
    run_job(16'hFFFE, 16'h0001, 8'd1, 4'hF, 0, 1, 0, -1, 0);
    check("wrap_addr2", 32'((ren_addr.size() > 2) ? ren_addr[2] : 16'hDEAD), 32'h0);

    // Reset mid-run, then a fresh run matches single-tile timing
    run_job(16'h0500, 16'h0002, 8'd2, 4'hF, 0, 1, 0, -1, 6);
    run_job(16'h0010, 16'h0002, 8'd1, 4'hF, 0, 1, 0, -1, 0);
    check_single_tile_timing("rerun");

    // Randomized jobs with random backpressure
    for (int j = 0; j < 8; j++) begin
      run_job(16'($urandom), 16'($urandom), 8'($urandom_range(1, 4)), 4'($urandom),
              1, 1, 0, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tb_fetch_scheduler.md
# tb_fetch_scheduler

Controller that sequences a double-banked transpose buffer: it issues row reads to the on-chip memory, steers returning words into the fill bank, tracks bank ownership, and drains full banks column by column to a ready/valid consumer. It sits between the memory read port and the transpose buffer and supplies every buffer control signal (write bank/row, lane mask, read bank/column). One run transfers a configured number of tiles; each tile is TB_HEIGHT rows × FETCH_WIDTH columns.

## Interface
- FETCH_WIDTH, 4: words per memory row = columns per tile (power of two, ≥2)
- TB_HEIGHT, 3: rows per bank (≥2)
- ADDR_W, 16: memory address width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- cfg_base  in  ADDR_W  address of first row
- cfg_stride  in  ADDR_W  address increment per row
- cfg_num_tiles  in  8  tiles to transfer
- cfg_lane_mask  in  FETCH_WIDTH  valid-lane mask forwarded to buffer
- mem_ren  out  1  memory read request; data returns exactly 1 cycle later
- mem_addr  out  ADDR_W  read address
- tb_wen  out  1  buffer row write (aligned with returned data)
- tb_wr_bank  out  1  bank written
- tb_wr_row  out  clog2(TB_HEIGHT)  row written
- tb_valid_input  out  FETCH_WIDTH  latched mask when tb_wen, else 0
- out_valid  out  1  column available
- out_ready  in  1  consumer accepts column
- tb_rd_bank  out  1  bank being drained
- tb_rd_col  out  clog2(FETCH_WIDTH)  column being drained
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of run

## Operation
- States: IDLE, RUN. IDLE: start=1 latches all cfg_*, zeroes counters; if cfg_num_tiles=0 pulse done next cycle and stay IDLE, else go RUN. start in RUN ignored.
- Per-bank flags alloc[b], full[b]. Issue side: iss_bank, iss_row, iss_tiles, addr register (init cfg_base).
- Issue rule (RUN): mem_ren=1 when !alloc[iss_bank] and iss_tiles<num_tiles. On issue: alloc[iss_bank] set, addr += stride (mod 2^ADDR_W), iss_row++; at iss_row=TB_HEIGHT-1 wrap to 0, toggle iss_bank, iss_tiles++.
- Write side: the issue’s bank/row pipelined one cycle; tb_wen=1 the cycle after each mem_ren. Write of row TB_HEIGHT-1 sets full[bank] at that edge.
- Drain side: out_valid=full[rd_bank]. On out_valid&out_ready: rd_col++; at rd_col=FETCH_WIDTH-1 clear alloc and full of rd_bank, rd_col→0, toggle rd_bank, done_tiles++. out_ready low holds col/bank stable.
- Run end: the cycle the last column of tile num_tiles is accepted, state→IDLE and done=1 next cycle, busy=0 then.
- Banks always filled and drained in order 0,1,0,1…; iss_bank/rd_bank reset to 0 each run.

## Timing
- Reset: all outputs 0, state IDLE, all flags/counters 0, addr 0.
- Cycle 0 start=1 (TB_HEIGHT=3, FETCH_WIDTH=4, ready=1): mem_ren cycles 1–3 (bank0), 4–6 (bank1); tb_wen cycles 2–7; full[0] visible cycle 5; out_valid cycles 5–8 bank0, 9–12 bank1.
- Bank free→reissue: clear at drain edge; issue to that bank earliest next cycle (alloc read is registered). Same-cycle clear and issue request: no issue that cycle.
- full set and drain: out_valid rises the cycle after the last row write, never same cycle.
- Steady state with ready=1: no output bubbles once both banks in use (fill time TB_HEIGHT ≤ drain time FETCH_WIDTH).
- Backpressure: ready=0 stalls drain only; issue continues until both banks allocated, then mem_ren=0.
- rst mid-run: next cycle IDLE, all outputs 0, in-flight read data discarded (tb_wen=0).

## Test plan
- Single tile, base=0x10, stride=2, ready=1: mem_addr 0x10,0x12,0x14 cycles 1–3; tb_wr_row 0,1,2 cycles 2–4; tb_rd_col 0..3 cycles 5–8; done cycle 9.
- Three tiles, ready=1: 12 contiguous out_valid cycles 5–16, rd_bank 0,1,0; 9 mem_ren; done cycle 17.
- Backpressure: two tiles, ready=0 cycles 5–20: out_valid held, tb_rd_col=0, mem_ren stops after 6 issues; release → 8 columns over 8 cycles.
- num_tiles=0: start → done at cycle 1, no mem_ren, busy stays 0; start during RUN ignored (cfg unchanged).
- Address wrap: base=0xFFFE, stride=1: addresses 0xFFFE,0xFFFF,0x0000.
- Reset at cycle 6 of 2-tile run: cycle 7 all outputs 0; fresh start reproduces scenario-1 timing.
